counter_seq_ctrl: RTL and testbench

//  Sequencer for the preloadable up-counter (load strobe, step strobe, preload value).

---
 rtl/counter_ctrl_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 45 ++++
 rtl/counter_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and run descriptor.
// Latency: n/a (types and default widths only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  localparam int CTRL_WIDTH = 8;
  localparam int CTRL_DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_e;

  // One run request at the default widths: preload value, terminal value,
  // prescaler divider and the auto-reload flag.
  typedef struct packed {
    logic [CTRL_WIDTH-1:0] start_val;
    logic [CTRL_WIDTH-1:0] end_val;
    logic [CTRL_DIV_W-1:0] div_val;
    logic                  reload;
  } run_desc_t;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..div and flags the terminal count as tick.
// Latency: tick is a pure compare on the registered count (same cycle).
// Backpressure: hold freezes the count in place; clear forces it to zero.
module tick_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int DIV_W = CTRL_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = (cnt_q == div);

  // Next count: clear wins over hold; a tick while counting wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Count register, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a preloadable up-counter: accept a run descriptor, preload, step at a prescaled rate to end.
// Latency: accept at N -> LOAD at N+1 -> RUN at N+2; run = steps*(div+1)+3 cycles without pause.
// Backpressure: cfg_ready is high only in IDLE; pause freezes stepping and the prescaler.
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CTRL_WIDTH,
  parameter int DIV_W = CTRL_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_reload,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_v,
  output logic             busy,
  output logic             done
);

  // Descriptor at this instance's widths (the package type fixes the defaults).
  typedef struct packed {
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic [DIV_W-1:0] div_val;
    logic             reload;
  } desc_t;

  state_e state_q;
  state_e state_d;
  desc_t  desc_q;
  desc_t  desc_d;

  logic presc_clear;
  logic presc_hold;
  logic presc_tick;
  logic end_hit;

  // The counter feedback is compared against the stored terminal value only,
  // so nothing on the cfg_* inputs can reach the cnt_* outputs combinationally.
  assign end_hit = (cnt_q == desc_q.end_val);

  // The preload value is always presented; the counter only takes it on cnt_load.
  assign cnt_v = desc_q.start_val;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .hold  (presc_hold),
    .div   (desc_q.div_val),
    .tick  (presc_tick)
  );

  // State and descriptor registers; reset drops any run in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
    end
  end

  // Next-state and output decode. Priority inside a run: abort, end reached, pause.
  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    cfg_ready   = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    presc_clear = 1'b0;
    presc_hold  = 1'b1;

    case (state_q)
      IDLE: begin
        // abort has nothing to cancel here and is ignored.
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          desc_d.start_val = cfg_start;
          desc_d.end_val   = cfg_end;
          desc_d.div_val   = cfg_div;
          desc_d.reload    = cfg_reload;
          state_d          = LOAD;
        end
      end

      LOAD: begin
        // Load and step are raised together; the counter gives load priority.
        // pause is not looked at until the first RUN cycle.
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_load    = 1'b1;
          cnt_en      = 1'b1;
          presc_clear = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (end_hit) begin
          state_d = DONE;
        end else if (pause) begin
          // Freeze right away so the held prescaler value is resumed exactly.
          state_d = PAUSED;
        end else begin
          presc_hold = 1'b0;
          cnt_en     = presc_tick;
        end
      end

      PAUSED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        // An abort here swallows the completion pulse and any pending reload.
        if (abort) begin
          state_d = IDLE;
        end else begin
          done    = 1'b1;
          state_d = desc_q.reload ? LOAD : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: drives descriptors, pause and abort against an attached counter.
// Expected timing is derived from run arithmetic: steps = (end-start) mod 256, length = steps*(div+1)+3.
// A pause window that starts while stepping is outstanding stretches the run by its length plus one.
module tb_counter_seq_ctrl;
  import counter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_start;
  logic [7:0]  cfg_end;
  logic [15:0] cfg_div;
  logic        cfg_reload;
  logic        pause;
  logic        abort;
  logic [7:0]  ctr = 8'd0;
  logic        cnt_load;
  logic        cnt_en;
  logic [7:0]  cnt_v;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(
    .WIDTH (8),
    .DIV_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_end    (cfg_end),
    .cfg_div    (cfg_div),
    .cfg_reload (cfg_reload),
    .pause      (pause),
    .abort      (abort),
    .cnt_q      (ctr),
    .cnt_load   (cnt_load),
    .cnt_en     (cnt_en),
    .cnt_v      (cnt_v),
    .busy       (busy),
    .done       (done)
  );

  // The preloadable up-counter being sequenced: load has priority over step.
  always @(posedge clk) begin
    if (cnt_load) ctr <= cnt_v;
    else if (cnt_en) ctr <= ctr + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One non-reloading run with an optional pause window [p_at, p_at+p_len),
  // where t counts cycles after the accept cycle (t=1 is the preload cycle).
  task automatic run_one(input run_desc_t rd, input int p_at, input int p_len);
    logic [7:0] diff;
    int steps, span, pen, exp_len, dv;
    int t, done_t, en_n, load_n, pv, bg, last_en, first_en, rel_en, held;
    bit in_win;
    diff    = rd.end_val - rd.start_val;
    steps   = int'(diff);
    dv      = int'(rd.div_val) + 1;
    span    = steps * dv;
    in_win  = (p_len > 0) && (p_at <= 1 + span);
    pen     = in_win ? p_len + 1 : 0;
    exp_len = span + 3 + pen;

    cfg_start  = rd.start_val;
    cfg_end    = rd.end_val;
    cfg_div    = rd.div_val;
    cfg_reload = rd.reload;
    cfg_valid  = 1'b1;
    @(negedge clk);
    chk("accept_ready", cfg_ready, 1);
    nxt();
    cfg_valid  = 1'b0;
    cfg_start  = 8'($urandom);
    cfg_end    = 8'($urandom);
    cfg_div    = 16'($urandom);

    t = 1; done_t = -1; en_n = 0; load_n = 0; pv = 0; bg = 0;
    last_en = -1; first_en = -1; rel_en = -1;
    while (done_t < 0 && t <= exp_len + 16) begin
      pause = (p_len > 0) && (t >= p_at) && (t < p_at + p_len);
      @(negedge clk);
      if (cnt_load) begin
        load_n++;
        chk("load_val", cnt_v, rd.start_val);
      end
      if (cnt_en && !cnt_load) begin
        en_n++;
        if (pause) pv++;
        if (p_len == 0 && last_en >= 0) chk("step_gap", t - last_en, dv);
        if (first_en < 0) first_en = t;
        if (in_win && rel_en < 0 && t >= p_at + p_len) rel_en = t;
        last_en = t;
      end
      if (!busy) bg++;
      if (done) begin
        done_t = t;
        chk("end_val", ctr, rd.end_val);
      end
      nxt();
      t++;
    end
    pause = 1'b0;

    chk("run_len", done_t, exp_len);
    chk("steps", en_n, steps);
    chk("loads", load_n, 1);
    chk("step_in_pause", pv, 0);
    chk("busy_gap", bg, 0);
    if (p_len == 0 && steps > 0) chk("first_step", first_en, 1 + dv);
    if (in_win) begin
      held = (p_at - 2) % dv;
      chk("resume_step", rel_en, p_at + p_len + dv - held);
    end

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cfg_ready, 1);
    chk("idle_done", done, 0);
    nxt();
  endtask

  initial begin
    run_desc_t rd;
    int span, pa, pl;
    rst = 1'b1; cfg_valid = 1'b0; cfg_start = '0; cfg_end = '0; cfg_div = '0;
    cfg_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (3) nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_v", cnt_v, 0);
    nxt();

    // Basic run, wrap through 255, start==end, pause mid-run, pause on the end cycle.
    rd = '{start_val: 8'd3,   end_val: 8'd7,  div_val: 16'd0, reload: 1'b0}; run_one(rd, 0, 0);
    rd = '{start_val: 8'd250, end_val: 8'd2,  div_val: 16'd1, reload: 1'b0}; run_one(rd, 0, 0);
    rd = '{start_val: 8'd9,   end_val: 8'd9,  div_val: 16'd0, reload: 1'b0}; run_one(rd, 0, 0);
    rd = '{start_val: 8'd0,   end_val: 8'd5,  div_val: 16'd3, reload: 1'b0}; run_one(rd, 10, 10);
    rd = '{start_val: 8'd10,  end_val: 8'd13, div_val: 16'd1, reload: 1'b0}; run_one(rd, 8, 3);

    // Randomised descriptors, idle gaps and pause windows.
    for (int i = 0; i < 12; i++) begin
      rd.start_val = 8'($urandom);
      rd.end_val   = rd.start_val + 8'($urandom_range(0, 12));
      rd.div_val   = 16'($urandom_range(0, 3));
      rd.reload    = 1'b0;
      span = int'(8'(rd.end_val - rd.start_val)) * (int'(rd.div_val) + 1);
      if ($urandom_range(0, 1) == 1) begin
        pa = int'($urandom_range(2, 2 + span));
        pl = int'($urandom_range(1, 6));
      end else begin
        pa = 0;
        pl = 0;
      end
      repeat ($urandom_range(0, 2)) nxt();
      run_one(rd, pa, pl);
    end

    // Auto-reload: done every 5 cycles, new descriptors ignored, abort on a done cycle.
    cfg_start = 8'd1; cfg_end = 8'd3; cfg_div = 16'd0; cfg_reload = 1'b1; cfg_valid = 1'b1;
    @(negedge clk);
    chk("t5_ready", cfg_ready, 1);
    nxt();
    cfg_start = 8'd100; cfg_end = 8'd120; cfg_reload = 1'b0;
    for (int t = 1; t <= 35; t++) begin
      abort = (t == 35);
      if (t == 35) cfg_valid = 1'b0;
      @(negedge clk);
      chk("t5_done", done, (t % 5 == 0) && (t != 35));
      chk("t5_ready", cfg_ready, 0);
      if (cnt_load) chk("t5_load_val", cnt_v, 1);
      nxt();
    end
    abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_ready", cfg_ready, 1);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_load", cnt_load, 0);
    nxt();

    // Reset in the middle of a run with a descriptor on offer.
    cfg_start = 8'd0; cfg_end = 8'd200; cfg_div = 16'd20; cfg_reload = 1'b0; cfg_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready", cfg_ready, 1);
    nxt();
    cfg_valid = 1'b0;
    repeat (6) nxt();
    @(negedge clk);
    chk("t6_busy_run", busy, 1);
    nxt();
    rst = 1'b1; cfg_valid = 1'b1; cfg_start = 8'd7; cfg_end = 8'd8; cfg_div = 16'd0;
    nxt();
    rst = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("t6_load", cnt_load, 0);
    chk("t6_en", cnt_en, 0);
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 0);
    chk("t6_v", cnt_v, 0);
    chk("t6_ready_after", cfg_ready, 1);
    nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_not_latched", busy, 0);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
